wire_arith_engine: RTL and testbench
====================================

Name: wire_arith_engine

Overview:
- Multi-cycle arithmetic unit between the host WireIn endpoints (operands, control) and the WireOut endpoints (results, status), all in the okClk domain.
- Replaces the single-cycle combinational add with host-started add/sub/multiply/divide.
- Reports a busy/done handshake so host software can poll status.

Parameters:
- WIDTH, 32, operand and result width in bits; 2..32.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- okClk  input  1  host interface clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_a  input  WIDTH  operand A, driven from a WireIn.
- op_b  input  WIDTH  operand B, driven from a WireIn.
- ctrl  input  32  control WireIn: bit0 start (edge-sensitive), bits[2:1] opcode, other bits ignored.
- result_lo  output  WIDTH  low result word for a WireOut.
- result_hi  output  WIDTH  high result word for a WireOut.
- status  output  32  bit0 busy, bit1 done, bit2 overflow, bit3 div0, bits[8+:CNT_W] ops completed, bits[31:16] cycle count (optional feature), rest 0.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; result_lo=0, result_hi=0; all status bits 0; start-edge history register=0.
- Start detect: registered copy of ctrl[0]. An accepted start is ctrl[0]=1 with previous sample 0 while the state is IDLE or DONE.
- Start edges seen while BUSY are dropped, not queued. Holding ctrl[0]=1 does not retrigger.
- Accept edge E0:
  - latch op_a, op_b and opcode;
  - busy<=1; clear done, overflow and div0;
  - state<=EXEC.
- Opcodes: 00 add, 01 sub, 10 unsigned multiply, 11 unsigned divide.
- add (00):
  - At E1: result_lo = a+b mod 2^WIDTH; result_hi = {0.., carry}; overflow = carry.
  - busy high exactly 1 cycle.
- sub (01):
  - At E1: result_lo = a-b mod 2^WIDTH; result_hi = {0.., borrow}; overflow = borrow (a<b).
- mul (10):
  - Shift-add, one bit per cycle, WIDTH iterations.
  - Full 2*WIDTH product written at E(WIDTH+1): hi in result_hi, lo in result_lo.
  - overflow = (hi != 0).
  - busy high WIDTH+1 cycles.
- div (11):
  - Restoring division, WIDTH iterations. Quotient in result_lo, remainder in result_hi, written at E(WIDTH+1).
  - Divide by zero completes at E1: result_lo = all ones, result_hi = a, div0=1, overflow=0.
- Completion edge:
  - busy<=0, done<=1, state<=DONE;
  - op counter +1, wrapping mod 2^CNT_W.
- result_lo/result_hi change only on a completion edge. They hold across the next operation until that operation completes.
- DONE behaves as IDLE for start acceptance. done stays set until the next accepted start.
- Operand or opcode changes after E0 do not affect the operation in flight.
- Reset mid-operation aborts immediately: everything returns to reset values, including the op counter.

Optional Feature:
- Macro: WIRE_ARITH_CYCLE_COUNT_EN.
- Defined:
  - 16-bit counter cleared on an accepted start, incremented each cycle busy=1, saturating at FFFF.
  - Value is frozen after completion and driven on status[31:16].
  - Expected final values: 1 for add, sub and divide by zero; WIDTH+1 for multiply and divide.
- Undefined: no counter logic; status[31:16] is tied to 0.

Test Plan:
- Add carry (WIDTH=32): a=FFFFFFFF, b=00000001, opcode 00, pulse ctrl[0] → result_lo=0, result_hi=1, overflow=1, busy high 1 cycle, done=1, op count=1.
- Sub borrow: a=5, b=7, opcode 01 → result_lo=FFFFFFFE, result_hi=1, overflow=1; then a=7, b=5 → result_lo=2, result_hi=0, overflow=0, op count=2.
- Multiply: a=00010000, b=00010000, opcode 10 → result_hi=1, result_lo=0, overflow=1, busy high exactly 33 cycles (cycle count=33 with WIRE_ARITH_CYCLE_COUNT_EN).
- Divide: a=100, b=7, opcode 11 → result_lo=14, result_hi=2 after 33 busy cycles. Then a=1234, b=0 → result_lo=FFFFFFFF, result_hi=1234, div0=1, busy high 1 cycle.
- Start while busy: multiply in flight, second ctrl[0] pulse 10 cycles after E0 → ignored, single completion, op count +1 only. Holding ctrl[0] high after completion → no retrigger.
- Reset mid-multiply: assert rst_n low at cycle 15 → busy=0, done=0, results=0, op count=0 asynchronously. Subsequent 3+4 add → result_lo=7.

Source files
------------

// File: rtl/wire_arith_engine.sv
// wire_arith_engine: host-started multi-cycle add/sub/multiply/divide unit
// sitting between the WireIn endpoints (operands, control) and the WireOut
// endpoints (results, status), all clocked by okClk.
//
// Ports:
//   okClk      host interface clock, rising edge
//   rst_n      asynchronous active-low reset
//   op_a/op_b  operands (WIDTH bits)
//   ctrl       bit0 start (rising edge), bits[2:1] opcode
//              (00 add, 01 sub, 10 unsigned mul, 11 unsigned div)
//   result_lo  low result word / quotient
//   result_hi  high result word / remainder / carry-borrow
//   status     bit0 busy, bit1 done, bit2 overflow, bit3 div0,
//              bits[8+:CNT_W] completed-op count, bits[31:16] cycle count
//
// Optional feature macro: WIRE_ARITH_CYCLE_COUNT_EN
//   defined   -> saturating 16-bit busy-cycle counter on status[31:16]
//   undefined -> status[31:16] tied to 0
module wire_arith_engine #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             okClk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [31:0]      ctrl,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [31:0]      status
);

   localparam int unsigned IW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_start_q;
   logic [1:0]       r_opc;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [IW-1:0]    r_iter;
   logic [WIDTH-1:0] r_result_lo;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_busy;
   logic             r_done;
   logic             r_ovf;
   logic             r_div0;
   logic [CNT_W-1:0] r_ops_cnt;

   logic             w_start;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_diff;
   logic             w_iter_done;
   logic             w_fin;
   logic [WIDTH-1:0] w_fin_lo;
   logic [WIDTH-1:0] w_fin_hi;
   logic             w_fin_ovf;
   logic             w_fin_div0;
   logic [15:0]      w_cyc_cnt;
   logic [31:0]      w_status;
   logic             w_ctrl_unused;

   // Only the start bit and opcode are meaningful in the control word
   assign w_ctrl_unused = ^ctrl[31:3];

   // Rising edge of ctrl[0], honoured only when no operation is in flight
   assign w_start = ctrl[0] & ~r_start_q & ((r_state == S_IDLE) | (r_state == S_DONE));

   // Single-cycle add/sub with carry/borrow in the top bit
   assign w_add = {1'b0, r_a} + {1'b0, r_b};
   assign w_sub = {1'b0, r_a} - {1'b0, r_b};

   // Shift-add multiply step: acc_hi accumulates, acc_lo holds the
   // remaining multiplier bits and collects product bits from the top
   assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : '0);

   // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts
   // dividend bits out of the top and quotient bits in at the bottom
   assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
   assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

   assign w_iter_done = (r_iter == IW'(WIDTH));

   // Completion condition and final result for the operation in flight
   always_comb begin
      w_fin      = 1'b0;
      w_fin_lo   = '0;
      w_fin_hi   = '0;
      w_fin_ovf  = 1'b0;
      w_fin_div0 = 1'b0;
      case (r_opc)
         OP_ADD: begin
            w_fin     = 1'b1;
            w_fin_lo  = w_add[WIDTH-1:0];
            w_fin_hi  = WIDTH'(w_add[WIDTH]);
            w_fin_ovf = w_add[WIDTH];
         end
         OP_SUB: begin
            w_fin     = 1'b1;
            w_fin_lo  = w_sub[WIDTH-1:0];
            w_fin_hi  = WIDTH'(w_sub[WIDTH]);
            w_fin_ovf = w_sub[WIDTH];
         end
         OP_MUL: begin
            w_fin     = w_iter_done;
            w_fin_lo  = r_acc_lo;
            w_fin_hi  = r_acc_hi;
            w_fin_ovf = |r_acc_hi;
         end
         default: begin
            if (r_b == '0) begin
               // Divide by zero short-circuits on the first exec cycle
               w_fin      = 1'b1;
               w_fin_lo   = '1;
               w_fin_hi   = r_a;
               w_fin_div0 = 1'b1;
            end else begin
               w_fin    = w_iter_done;
               w_fin_lo = r_acc_lo;
               w_fin_hi = r_acc_hi;
            end
         end
      endcase
   end

   // Control FSM, datapath iteration and registered outputs
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_start_q   <= 1'b0;
         r_opc       <= 2'b00;
         r_a         <= '0;
         r_b         <= '0;
         r_acc_hi    <= '0;
         r_acc_lo    <= '0;
         r_iter      <= '0;
         r_result_lo <= '0;
         r_result_hi <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
         r_div0      <= 1'b0;
         r_ops_cnt   <= '0;
      end else begin
         r_start_q <= ctrl[0];
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_a      <= op_a;
                  r_b      <= op_b;
                  r_opc    <= ctrl[2:1];
                  r_acc_hi <= '0;
                  r_acc_lo <= (ctrl[2:1] == OP_MUL) ? op_b : op_a;
                  r_iter   <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_div0   <= 1'b0;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_fin) begin
                  r_result_lo <= w_fin_lo;
                  r_result_hi <= w_fin_hi;
                  r_ovf       <= w_fin_ovf;
                  r_div0      <= w_fin_div0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_ops_cnt   <= r_ops_cnt + CNT_W'(1);
                  r_state     <= S_DONE;
               end else begin
                  r_iter <= r_iter + IW'(1);
                  if (r_opc == OP_MUL) begin
                     r_acc_hi <= w_mul_sum[WIDTH:1];
                     r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                  end else begin
                     r_acc_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                     r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef WIRE_ARITH_CYCLE_COUNT_EN
   logic [15:0] r_cyc_cnt;

   // Busy-cycle counter: cleared on accept, frozen once busy drops
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc_cnt <= '0;
      end else if (w_start) begin
         r_cyc_cnt <= '0;
      end else if (r_busy && (r_cyc_cnt != 16'hFFFF)) begin
         r_cyc_cnt <= r_cyc_cnt + 16'd1;
      end
   end

   assign w_cyc_cnt = r_cyc_cnt;
`else
   assign w_cyc_cnt = '0;
`endif

   // Status word assembly from registered flags
   always_comb begin
      w_status               = '0;
      w_status[0]            = r_busy;
      w_status[1]            = r_done;
      w_status[2]            = r_ovf;
      w_status[3]            = r_div0;
      w_status[8 +: CNT_W]   = r_ops_cnt;
      w_status[31:16]        = w_cyc_cnt;
   end

   assign result_lo = r_result_lo;
   assign result_hi = r_result_hi;
   assign status    = w_status;

endmodule

// File: tb/tb_wire_arith_engine.sv
// Testbench for wire_arith_engine: directed operations checked every cycle
// against a spec-level arithmetic model, plus hand-computed literals.
module tb_wire_arith_engine;

   localparam int unsigned W = 32;

   logic          okClk;
   logic          rst_n;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [31:0]   ctrl;
   logic [W-1:0]  result_lo;
   logic [W-1:0]  result_hi;
   logic [31:0]   status;

   int total = 0;
   int bad   = 0;

   wire_arith_engine #(.WIDTH(W), .CNT_W(8)) dut (
      .okClk     (okClk),
      .rst_n     (rst_n),
      .op_a      (op_a),
      .op_b      (op_b),
      .ctrl      (ctrl),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .status    (status)
   );

   initial begin
      okClk = 1'b0;
      forever #5 okClk = ~okClk;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic         m_prev  = 1'b0;
   logic         m_busy  = 1'b0;
   logic         m_done  = 1'b0;
   logic         m_ovf   = 1'b0;
   logic         m_div0  = 1'b0;
   logic [31:0]  m_lo    = '0;
   logic [31:0]  m_hi    = '0;
   logic [7:0]   m_cnt   = '0;
   logic [15:0]  m_cyc   = '0;
   int           m_left  = 0;
   logic [31:0]  p_lo, p_hi;
   logic         p_ovf, p_div0;
   logic [63:0]  m_wide;

   initial begin
      forever begin
         @(posedge okClk or negedge rst_n);
         if (!rst_n) begin
            m_prev = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_div0 = 1'b0;
            m_lo = '0; m_hi = '0; m_cnt = '0; m_cyc = '0; m_left = 0;
         end else begin
            if (m_busy && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
            if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 1'b0; m_done = 1'b1;
                  m_lo = p_lo; m_hi = p_hi; m_ovf = p_ovf; m_div0 = p_div0;
                  m_cnt = m_cnt + 8'd1;
               end
            end else if (ctrl[0] && !m_prev) begin
               p_div0 = 1'b0;
               case (ctrl[2:1])
                  2'b00: begin
                     m_wide = {32'd0, op_a} + {32'd0, op_b};
                     p_lo = m_wide[31:0]; p_ovf = m_wide[32]; p_hi = {31'd0, p_ovf};
                     m_left = 1;
                  end
                  2'b01: begin
                     p_lo = op_a - op_b; p_ovf = (op_a < op_b); p_hi = {31'd0, p_ovf};
                     m_left = 1;
                  end
                  2'b10: begin
                     m_wide = {32'd0, op_a} * {32'd0, op_b};
                     p_lo = m_wide[31:0]; p_hi = m_wide[63:32]; p_ovf = (p_hi != 0);
                     m_left = W + 1;
                  end
                  default: begin
                     p_ovf = 1'b0;
                     if (op_b == 0) begin
                        p_lo = '1; p_hi = op_a; p_div0 = 1'b1; m_left = 1;
                     end else begin
                        p_lo = op_a / op_b; p_hi = op_a % op_b; m_left = W + 1;
                     end
                  end
               endcase
               m_busy = 1'b1; m_done = 1'b0; m_ovf = 1'b0; m_div0 = 1'b0; m_cyc = '0;
            end
            m_prev = ctrl[0];
         end
      end
   end

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = m_busy; s[1] = m_done; s[2] = m_ovf; s[3] = m_div0;
      s[15:8] = m_cnt;
`ifdef WIRE_ARITH_CYCLE_COUNT_EN
      s[31:16] = m_cyc;
`endif
      return s;
   endfunction

   // Per-cycle compare against the model, away from the active edge
   initial begin
      forever begin
         @(negedge okClk);
         check32("cyc result_lo", result_lo, m_lo);
         check32("cyc result_hi", result_hi, m_hi);
         check32("cyc status", status, model_status());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc,
                         input int exp_busy, input string nm);
      int n;
      @(posedge okClk); #2;
      op_a = a; op_b = b; ctrl = {29'd0, opc, 1'b1};
      @(posedge okClk); #2;
      // operands and opcode scrambled after acceptance must not matter
      op_a = ~a; op_b = ~b; ctrl = {29'h1FFF_FFFF, ~opc, 1'b0};
      n = 0;
      while (status[0] === 1'b1 && n < 200) begin
         @(posedge okClk); #2;
         n++;
      end
      check32({nm, " busy_cycles"}, 32'(n), 32'(exp_busy));
      ctrl = 32'd0;
   endtask

   task automatic check_cyc(input string nm, input logic [15:0] exp);
`ifdef WIRE_ARITH_CYCLE_COUNT_EN
      check32({nm, " cycle_count"}, {16'd0, status[31:16]}, {16'd0, exp});
`else
      check32({nm, " cycle_count_tied"}, {16'd0, status[31:16]}, 32'd0);
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst_n = 1'b0; ctrl = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge okClk);
      #2;
      check32("reset result_lo", result_lo, 32'h0);
      check32("reset result_hi", result_hi, 32'h0);
      check32("reset status", status, 32'h0);
      rst_n = 1'b1;

      run_op(32'hFFFF_FFFF, 32'h1, 2'b00, 1, "add");
      check32("add lo", result_lo, 32'h0);
      check32("add hi", result_hi, 32'h1);
      check32("add status", {16'd0, status[15:0]}, 32'h0106);
      check_cyc("add", 16'd1);

      run_op(32'd5, 32'd7, 2'b01, 1, "sub1");
      check32("sub1 lo", result_lo, 32'hFFFF_FFFE);
      check32("sub1 hi", result_hi, 32'h1);
      check32("sub1 status", {16'd0, status[15:0]}, 32'h0206);

      run_op(32'd7, 32'd5, 2'b01, 1, "sub2");
      check32("sub2 lo", result_lo, 32'h2);
      check32("sub2 hi", result_hi, 32'h0);
      check32("sub2 status", {16'd0, status[15:0]}, 32'h0302);

      run_op(32'h0001_0000, 32'h0001_0000, 2'b10, 33, "mul1");
      check32("mul1 lo", result_lo, 32'h0);
      check32("mul1 hi", result_hi, 32'h1);
      check32("mul1 status", {16'd0, status[15:0]}, 32'h0406);
      check_cyc("mul1", 16'd33);

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 33, "mul2");
      check32("mul2 lo", result_lo, 32'h1);
      check32("mul2 hi", result_hi, 32'hFFFF_FFFE);
      check32("mul2 status", {16'd0, status[15:0]}, 32'h0506);

      run_op(32'd100, 32'd7, 2'b11, 33, "div1");
      check32("div1 quot", result_lo, 32'd14);
      check32("div1 rem", result_hi, 32'd2);
      check32("div1 status", {16'd0, status[15:0]}, 32'h0602);
      check_cyc("div1", 16'd33);

      run_op(32'd7, 32'd100, 2'b11, 33, "div2");
      check32("div2 quot", result_lo, 32'd0);
      check32("div2 rem", result_hi, 32'd7);
      check32("div2 status", {16'd0, status[15:0]}, 32'h0702);

      run_op(32'd1234, 32'd0, 2'b11, 1, "div0");
      check32("div0 lo", result_lo, 32'hFFFF_FFFF);
      check32("div0 hi", result_hi, 32'd1234);
      check32("div0 status", {16'd0, status[15:0]}, 32'h080A);
      check_cyc("div0", 16'd1);

      // start edge 10 cycles into a multiply, then ctrl[0] held high
      @(posedge okClk); #2;
      op_a = 32'd3; op_b = 32'd5; ctrl = 32'h5;
      @(posedge okClk); #2;
      ctrl[0] = 1'b0;
      n = 0;
      while (status[0] === 1'b1 && n < 200) begin
         if (n == 10) ctrl[0] = 1'b1;
         @(posedge okClk); #2;
         n++;
      end
      check32("busy_start busy_cycles", 32'(n), 32'd33);
      check32("busy_start lo", result_lo, 32'd15);
      check32("busy_start status", {16'd0, status[15:0]}, 32'h0902);
      repeat (40) @(posedge okClk);
      #2;
      check32("hold_high status", {16'd0, status[15:0]}, 32'h0902);
      ctrl = 32'd0;

      // asynchronous reset in the middle of a multiply
      @(posedge okClk); #2;
      op_a = 32'h0001_0000; op_b = 32'h0001_0000; ctrl = 32'h5;
      @(posedge okClk); #2;
      ctrl = 32'd0;
      repeat (15) @(posedge okClk);
      #2;
      check32("pre_reset busy", {31'd0, status[0]}, 32'd1);
      rst_n = 1'b0;
      #1;
      check32("midreset lo", result_lo, 32'h0);
      check32("midreset hi", result_hi, 32'h0);
      check32("midreset status", status, 32'h0);
      @(negedge okClk); #1;
      rst_n = 1'b1;

      run_op(32'd3, 32'd4, 2'b00, 1, "post_reset_add");
      check32("post_reset_add lo", result_lo, 32'd7);
      check32("post_reset_add status", {16'd0, status[15:0]}, 32'h0102);

      // 256 more operations wrap the 8-bit op counter back to 1
      for (int i = 0; i < 256; i++) begin
         run_op($urandom, $urandom, 2'($urandom_range(0, 1)), 1, "wrap_op");
      end
      check32("op_count wrap", {24'd0, status[15:8]}, 32'd1);

      repeat (3) @(posedge okClk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
